// File: rtl/last_three_sum_arbiter_if.sv
// -----------------------------------------------------------------------------
// last_three_sum_arbiter_if
// Bundles the two request channels and the result bus of the last-three-sum
// arbiter.
//   reqN_valid  : channel N offers a sample on reqN_d
//   reqN_d      : channel N sample, WIDTH bits
//   reqN_clear  : channel N history clear request
//   reqN_ready  : channel N sample accepted this cycle (with reqN_valid)
//   out_valid   : one-cycle pulse qualifying out_chan/out_sum/out_fill
//   out_chan    : channel the result belongs to
//   out_sum     : sum of that channel's last three samples, mod 2^WIDTH
//   out_fill    : number of real samples in the window, 1..3
// Modports: master = requester/consumer side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface last_three_sum_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic [WIDTH-1:0] req0_d;
   logic             req0_clear;
   logic             req0_ready;
   logic             req1_valid;
   logic [WIDTH-1:0] req1_d;
   logic             req1_clear;
   logic             req1_ready;
   logic             out_valid;
   logic             out_chan;
   logic [WIDTH-1:0] out_sum;
   logic [1:0]       out_fill;

   modport master (
      output req0_valid, req0_d, req0_clear,
      output req1_valid, req1_d, req1_clear,
      input  req0_ready, req1_ready,
      input  out_valid, out_chan, out_sum, out_fill
   );

   modport slave (
      input  req0_valid, req0_d, req0_clear,
      input  req1_valid, req1_d, req1_clear,
      output req0_ready, req1_ready,
      output out_valid, out_chan, out_sum, out_fill
   );
endinterface

// File: rtl/last_three_sum_arbiter.sv
// -----------------------------------------------------------------------------
// last_three_sum_arbiter
// Round-robin front end for two sample streams sharing one three-input adder.
// Each stream keeps its own three-deep history and fill count; every accepted
// sample produces, one cycle later, the sum of that stream's three newest
// samples tagged with the stream number.
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : slave modport of last_three_sum_arbiter_if (requests + results)
// -----------------------------------------------------------------------------
module last_three_sum_arbiter #(
   parameter int WIDTH = 8
) (
   input logic                     clk,
   input logic                     reset,
   last_three_sum_arbiter_if.slave bus
);

   typedef enum logic {
      PRI0 = 1'b0,
      PRI1 = 1'b1
   } pri_t;

   typedef struct packed {
      logic [WIDTH-1:0] h0;    // newest
      logic [WIDTH-1:0] h1;
      logic [WIDTH-1:0] h2;    // oldest
      logic [1:0]       fill;
   } hist_t;

   pri_t             r_pri;
   pri_t             w_pri_next;
   hist_t            r_hist [2];

   logic             r_out_valid;
   logic             r_out_chan;
   logic [WIDTH-1:0] r_out_sum;
   logic [1:0]       r_out_fill;

   logic [1:0]       w_elig;
   logic [1:0]       w_grant;
   logic [1:0]       w_clear;
   logic             w_accept;
   logic             w_sel;
   logic [WIDTH-1:0] w_d;
   hist_t            w_cur;
   logic [WIDTH-1:0] w_sum;
   logic [1:0]       w_fill_next;

   // A channel being cleared is never eligible, so clear and grant on the
   // same channel are mutually exclusive.
   assign w_clear = {bus.req1_clear, bus.req0_clear};
   assign w_elig  = {bus.req1_valid & ~bus.req1_clear,
                     bus.req0_valid & ~bus.req0_clear};

   // Arbiter next-state and grants.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the if/else tree can leave a value unassigned and infer a latch.
      w_grant    = 2'b00;
      w_pri_next = r_pri;
      if (w_elig == 2'b11) begin
         if (r_pri == PRI0) w_grant = 2'b01;
         else               w_grant = 2'b10;
      end else begin
         w_grant = w_elig;
      end
      // The winner hands priority to the other channel.
      if (w_grant[0])      w_pri_next = PRI1;
      else if (w_grant[1]) w_pri_next = PRI0;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset) r_pri <= PRI0;
      else        r_pri <= w_pri_next;
   end

   // Shared datapath: select the granted channel and add against its
   // pre-update history. Empty slots are zero, so partial windows work.
   assign w_accept    = |w_grant;
   assign w_sel       = w_grant[1];
   assign w_d         = w_sel ? bus.req1_d : bus.req0_d;
   assign w_cur       = r_hist[w_sel];
   assign w_sum       = w_d + w_cur.h0 + w_cur.h1;
   assign w_fill_next = (w_cur.fill == 2'd3) ? 2'd3 : w_cur.fill + 2'd1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: the history is only six words, and partial-window sums depend
         // on empty slots reading zero, so it is reset like ordinary registers.
         for (int c = 0; c < 2; c++) r_hist[c] <= '0;
         r_out_valid <= 1'b0;
         r_out_chan  <= 1'b0;
         r_out_sum   <= '0;
         r_out_fill  <= 2'd0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (w_clear[c]) begin
               r_hist[c] <= '0;
            end else if (w_grant[c]) begin
               r_hist[c].h2   <= r_hist[c].h1;
               r_hist[c].h1   <= r_hist[c].h0;
               r_hist[c].h0   <= w_d;
               r_hist[c].fill <= w_fill_next;
            end
         end
         r_out_valid <= w_accept;
         if (w_accept) begin
            r_out_chan <= w_sel;
            r_out_sum  <= w_sum;
            r_out_fill <= w_fill_next;
         end
      end
   end

   // Ready is forced low while reset is asserted.
   assign bus.req0_ready = w_grant[0] & reset;
   assign bus.req1_ready = w_grant[1] & reset;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_chan   = r_out_chan;
   assign bus.out_sum    = r_out_sum;
   assign bus.out_fill   = r_out_fill;

endmodule

// File: tb/tb_last_three_sum_arbiter.sv
// -----------------------------------------------------------------------------
// tb_last_three_sum_arbiter
// Directed and randomised bench for last_three_sum_arbiter. A reference model
// of the arbiter and per-channel histories pushes expected results to a queue
// when a sample is accepted; results are popped and compared on out_valid.
// -----------------------------------------------------------------------------
module tb_last_three_sum_arbiter;

   typedef struct {
      logic       chan;
      logic [7:0] sum;
      logic [1:0] fill;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   last_three_sum_arbiter_if #(.WIDTH(8)) bus ();

   last_three_sum_arbiter #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_total  = 0;
   int n_passed = 0;

   // Reference model state
   logic [7:0] m_h    [2][3];
   logic [1:0] m_fill [2];
   logic       m_pri;
   exp_t       m_last;
   exp_t       q [$];
   int         wait_cnt [2];
   logic       g0, g1;
   logic [15:0] lfsr = 16'hACE1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic lfsr_step();
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   endtask

   task automatic model_accept(input int c, input logic [7:0] d);
      exp_t e;
      e.chan = c[0];
      e.sum  = d + m_h[c][0] + m_h[c][1];
      e.fill = (m_fill[c] == 2'd3) ? 2'd3 : m_fill[c] + 2'd1;
      q.push_back(e);
      m_h[c][2] = m_h[c][1];
      m_h[c][1] = m_h[c][0];
      m_h[c][0] = d;
      m_fill[c] = e.fill;
   endtask

   // One clock cycle: drive, check ready against the model, update the model,
   // cross the edge, then compare the result bus.
   task automatic step(input logic rst,
                       input logic v0, input logic c0, input logic [7:0] d0,
                       input logic v1, input logic c1, input logic [7:0] d1);
      logic e0, e1, exp_v;
      exp_t e;
      reset          = rst;
      bus.req0_valid = v0; bus.req0_clear = c0; bus.req0_d = d0;
      bus.req1_valid = v1; bus.req1_clear = c1; bus.req1_d = d1;
      #4;
      e0 = rst & v0 & ~c0;
      e1 = rst & v1 & ~c1;
      g0 = e0 & (~e1 | (m_pri == 1'b0));
      g1 = e1 & (~e0 | (m_pri == 1'b1));
      check("ready0", bus.req0_ready, g0);
      check("ready1", bus.req1_ready, g1);
      check("one_ready", bus.req0_ready & bus.req1_ready, 0);
      if (e0) begin
         wait_cnt[0] = bus.req0_ready ? 0 : wait_cnt[0] + 1;
         check("starve0", wait_cnt[0] < 2, 1);
      end else wait_cnt[0] = 0;
      if (e1) begin
         wait_cnt[1] = bus.req1_ready ? 0 : wait_cnt[1] + 1;
         check("starve1", wait_cnt[1] < 2, 1);
      end else wait_cnt[1] = 0;

      if (!rst) begin
         for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 3; k++) m_h[c][k] = 8'd0;
            m_fill[c] = 2'd0;
         end
         m_pri  = 1'b0;
         m_last = '{chan: 1'b0, sum: 8'd0, fill: 2'd0};
         q.delete();
      end else begin
         if (c0) begin
            for (int k = 0; k < 3; k++) m_h[0][k] = 8'd0;
            m_fill[0] = 2'd0;
         end
         if (c1) begin
            for (int k = 0; k < 3; k++) m_h[1][k] = 8'd0;
            m_fill[1] = 2'd0;
         end
         if (g0) begin model_accept(0, d0); m_pri = 1'b1; end
         if (g1) begin model_accept(1, d1); m_pri = 1'b0; end
      end

      @(posedge clk);
      #1;
      exp_v = (q.size() > 0);
      check("out_valid", bus.out_valid, exp_v);
      if (exp_v) begin
         e = q.pop_front();
         m_last = e;
      end
      // With no accept the result fields must hold their previous values.
      check("out_chan", bus.out_chan, m_last.chan);
      check("out_sum",  bus.out_sum,  m_last.sum);
      check("out_fill", bus.out_fill, m_last.fill);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 8'hFF);
      wait_cnt[0] = 0;
      wait_cnt[1] = 0;
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
   endtask

   initial begin
      logic [7:0] t1_sum  [4];
      logic [1:0] t1_fill [4];
      logic [7:0] s0 [3];
      logic [7:0] s1 [3];
      logic [7:0] w1 [3];
      logic [7:0] c0_data [3];
      int i0, i1;
      logic pv0, pv1, sv0, sv1, sc0, sc1;
      logic [7:0] sd0, sd1;

      wait_cnt[0] = 0;
      wait_cnt[1] = 0;
      m_pri = 1'b0;
      reset = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_clear = 1'b0; bus.req0_d = 8'd0;
      bus.req1_valid = 1'b0; bus.req1_clear = 1'b0; bus.req1_d = 8'd0;
      @(posedge clk);
      #1;

      // Reset state, with requests present: ready low, outputs zero.
      do_reset();
      do_reset();
      idle();

      // Channel 0 alone: 10,20,30,40.
      t1_sum  = '{8'd10, 8'd30, 8'd60, 8'd90};
      t1_fill = '{2'd1, 2'd2, 2'd3, 2'd3};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0, 8'(10 * (i + 1)), 1'b0, 1'b0, 8'd0);
         check("t1_sum",  bus.out_sum,  t1_sum[i]);
         check("t1_fill", bus.out_fill, t1_fill[i]);
         check("t1_chan", bus.out_chan, 0);
      end
      idle();

      // Both channels held valid after reset: grants alternate from ch0.
      do_reset();
      s0 = '{8'd1, 8'd2, 8'd3};
      s1 = '{8'd100, 8'd100, 8'd100};
      i0 = 0;
      i1 = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, i0 < 3, 1'b0, s0[i0 < 3 ? i0 : 0], i1 < 3, 1'b0, s1[i1 < 3 ? i1 : 0]);
         check("t2_chan_order", bus.out_chan, i % 2);
         if (g0) i0++;
         if (g1) i1++;
      end
      check("t2_last_sum", bus.out_sum, 44);
      idle();

      // Wrap on channel 1: 200,100,50 -> 200,44,94.
      do_reset();
      w1 = '{8'd200, 8'd100, 8'd50};
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, w1[i]);
      check("wrap_sum",  bus.out_sum,  94);
      check("wrap_fill", bus.out_fill, 3);
      idle();

      // Clear on channel 0 while channel 1 is served.
      do_reset();
      c0_data = '{8'd5, 8'd6, 8'd7};
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, c0_data[i], 1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b1, 1'b1, 8'd8, 1'b1, 1'b0, 8'd77);
      check("clr_ch1_granted", bus.out_chan, 1);
      step(1'b1, 1'b1, 1'b0, 8'd9, 1'b0, 1'b0, 8'd0);
      check("clr_sum",  bus.out_sum,  9);
      check("clr_fill", bus.out_fill, 1);
      idle();

      // Reset in mid-stream, then restart from PRI0 with empty histories.
      for (int i = 0; i < 7; i++) begin
         lfsr_step();
         step(1'b1, 1'b1, 1'b0, lfsr[7:0], 1'b1, 1'b0, lfsr[15:8]);
      end
      do_reset();
      lfsr_step();
      step(1'b1, 1'b1, 1'b0, lfsr[7:0], 1'b1, 1'b0, lfsr[15:8]);
      check("rst_ch0_first", bus.out_chan, 0);
      check("rst_fill_one",  bus.out_fill, 1);

      // Randomised soak; data and valid held while a request is pending.
      pv0 = 1'b0; pv1 = 1'b0; sd0 = 8'd0; sd1 = 8'd0;
      for (int i = 0; i < 256; i++) begin
         lfsr_step();
         sc0 = (lfsr[3:0] == 4'd0);
         sc1 = (lfsr[7:4] == 4'd0);
         if (!pv0) begin sv0 = lfsr[8] | lfsr[9];   sd0 = lfsr[15:8]; end
         if (!pv1) begin sv1 = lfsr[10] | lfsr[11]; sd1 = lfsr[7:0] ^ lfsr[15:8]; end
         step(1'b1, sv0, sc0, sd0, sv1, sc1, sd1);
         pv0 = sv0 & ~g0;
         pv1 = sv1 & ~g1;
      end
      idle();

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
